// File: rtl/mrelbp_code_gen.sv
// MRELBP-NI code generator: collects one circle of interpolated samples, thresholds them against their mean.
// Optional rotation-invariant output is enabled by defining MRELBP_RI_EN.
//
// state   | meaning
// COLLECT | accept samples into the buffer and accumulate their sum
// MEAN    | mean = sum >> LOG2_PTS, clear sum
// CMP     | threshold every buffered sample against the mean
// ROT     | (MRELBP_RI_EN only) search for the minimum circular rotation of the code
// OUT     | present o_code / o_mean until downstream accepts
module mrelbp_code_gen #(
    parameter int FIXED    = 24,
    parameter int N_PTS    = 8,
    parameter int LOG2_PTS = 3
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    input  logic [FIXED-1:0] i_sample,
    output logic             o_ready,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [N_PTS-1:0] o_code,
    output logic [FIXED-1:0] o_mean
);

    localparam int SUM_W = FIXED + LOG2_PTS;

    typedef enum logic [2:0] {
        COLLECT,
        MEAN,
        CMP,
`ifdef MRELBP_RI_EN
        ROT,
`endif
        OUT
    } state_t;

    state_t               state;
    logic [FIXED-1:0]     samples [N_PTS];
    logic [SUM_W-1:0]     sum;
    logic [LOG2_PTS-1:0]  idx;
    logic [FIXED-1:0]     mean;
    logic [N_PTS-1:0]     code;

`ifdef MRELBP_RI_EN
    logic [LOG2_PTS-1:0]  rot_cnt;
    logic [N_PTS-1:0]     rot_min;
    logic [N_PTS-1:0]     rot_cur;
    logic [N_PTS-1:0]     rot_next;
    logic [2*N_PTS-1:0]   code_dbl;

    // Rotation order does not matter for a minimum, so the down-counter doubles as the shift amount.
    always_comb begin
        code_dbl = {code, code} >> rot_cnt;
        rot_cur  = code_dbl[N_PTS-1:0];
        rot_next = (rot_cur < rot_min) ? rot_cur : rot_min;
    end
`endif

    assign o_ready = i_rst_n && (state == COLLECT);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state   <= COLLECT;
            idx     <= '0;
            sum     <= '0;
            mean    <= '0;
            code    <= '0;
            o_valid <= 1'b0;
            o_code  <= '0;
            o_mean  <= '0;
`ifdef MRELBP_RI_EN
            rot_cnt <= '0;
            rot_min <= '1;
`endif
        end else begin
            case (state)
                COLLECT: begin
                    if (i_valid) begin
                        samples[idx] <= i_sample;
                        sum          <= sum + SUM_W'(i_sample);
                        idx          <= idx + LOG2_PTS'(1);
                        if (idx == LOG2_PTS'(N_PTS - 1)) begin
                            state <= MEAN;
                        end
                    end
                end
                MEAN: begin
                    // Sum of N_PTS FIXED-bit values shifted by LOG2_PTS always fits in FIXED bits.
                    mean  <= sum[SUM_W-1:LOG2_PTS];
                    sum   <= '0;
                    state <= CMP;
                end
                CMP: begin
                    for (int k = 0; k < N_PTS; k++) begin
                        code[k] <= (samples[k] >= mean);
                    end
`ifdef MRELBP_RI_EN
                    rot_cnt <= LOG2_PTS'(N_PTS - 1);
                    rot_min <= '1;
                    state   <= ROT;
`else
                    state   <= OUT;
`endif
                end
`ifdef MRELBP_RI_EN
                ROT: begin
                    rot_min <= rot_next;
                    if (rot_cnt == '0) begin
                        code  <= rot_next;
                        state <= OUT;
                    end else begin
                        rot_cnt <= rot_cnt - LOG2_PTS'(1);
                    end
                end
`endif
                OUT: begin
                    // First OUT cycle loads the output registers; handshake is only possible afterwards.
                    if (!o_valid) begin
                        o_valid <= 1'b1;
                        o_code  <= code;
                        o_mean  <= mean;
                    end else if (i_ready) begin
                        o_valid <= 1'b0;
                        state   <= COLLECT;
                    end
                end
                default: state <= COLLECT;
            endcase
        end
    end

endmodule

// File: tb/tb_mrelbp_code_gen.sv
// Scoreboard bench for mrelbp_code_gen: directed circles, expected code/mean queued at issue time.
module tb_mrelbp_code_gen;

    localparam int FIXED    = 24;
    localparam int N_PTS    = 8;
    localparam int LOG2_PTS = 3;
`ifdef MRELBP_RI_EN
    localparam int LAT = 3 + N_PTS;
`else
    localparam int LAT = 3;
`endif

    logic             i_clk = 1'b0;
    logic             i_rst_n = 1'b0;
    logic             i_valid = 1'b0;
    logic [FIXED-1:0] i_sample = '0;
    logic             i_ready = 1'b1;
    logic             o_ready;
    logic             o_valid;
    logic [N_PTS-1:0] o_code;
    logic [FIXED-1:0] o_mean;

    mrelbp_code_gen #(.FIXED(FIXED), .N_PTS(N_PTS), .LOG2_PTS(LOG2_PTS)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_valid  (i_valid),
        .i_sample (i_sample),
        .o_ready  (o_ready),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_code   (o_code),
        .o_mean   (o_mean)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [N_PTS-1:0] code;
        logic [FIXED-1:0] mean;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   last_acc = 0;
    int   outputs = 0;
    logic prev_valid = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge i_clk) cyc++;

    // Monitor: tracks accepts, checks latency, held outputs and pops on handshake.
    always @(negedge i_clk) begin
        if (i_valid && o_ready) last_acc = cyc + 1;
        if (o_valid) begin
            if (sb.size() == 0) begin
                check("spurious_valid", 32'(o_valid), 32'd0);
            end else begin
                if (!prev_valid) check("latency", 32'(cyc - last_acc), 32'(LAT));
                check("code", 32'(o_code), 32'(sb[0].code));
                check("mean", 32'(o_mean), 32'(sb[0].mean));
                check("ready_in_out", 32'(o_ready), 32'd0);
                if (i_ready) begin
                    void'(sb.pop_front());
                    outputs++;
                end
            end
        end
        prev_valid = o_valid;
    end

    task automatic send(input logic [FIXED-1:0] s);
        int t = 0;
        i_valid  = 1'b1;
        i_sample = s;
        @(negedge i_clk);
        while (!o_ready && t < 100) begin
            @(negedge i_clk);
            t++;
        end
        if (t >= 100) check("send_timeout", 32'(t), 32'd0);
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic circle(input logic [FIXED-1:0] s [N_PTS], input bit gaps,
                          input logic [N_PTS-1:0] code_raw, input logic [N_PTS-1:0] code_ri,
                          input logic [FIXED-1:0] mean);
        exp_t e;
`ifdef MRELBP_RI_EN
        e.code = code_ri;
`else
        e.code = code_raw;
`endif
        e.mean = mean;
        sb.push_back(e);
        for (int i = 0; i < N_PTS; i++) begin
            send(s[i]);
            if (gaps) begin
                repeat ($urandom_range(1, 3)) @(posedge i_clk);
                #1;
            end
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((sb.size() != 0 || o_valid) && t < 200) begin
            @(negedge i_clk);
            t++;
        end
        if (t >= 200) check("drain_timeout", 32'(t), 32'd0);
        @(posedge i_clk);
        #1;
    endtask

    logic [FIXED-1:0] ramp  [N_PTS];
    logic [FIXED-1:0] flat  [N_PTS];
    logic [FIXED-1:0] trunc [N_PTS];
    logic [FIXED-1:0] five  [N_PTS];

    initial begin
        for (int i = 0; i < N_PTS; i++) begin
            ramp[i]  = 24'h000A00 * 24'(i + 1);
            flat[i]  = 24'h001000;
            trunc[i] = (i == N_PTS - 1) ? 24'h00000F : 24'h000000;
            five[i]  = 24'h000500;
        end

        repeat (2) @(negedge i_clk);
        check("rst_valid", 32'(o_valid), 32'd0);
        check("rst_code", 32'(o_code), 32'd0);
        check("rst_mean", 32'(o_mean), 32'd0);
        check("rst_ready", 32'(o_ready), 32'd0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        @(negedge i_clk);
        check("ready_after_rst", 32'(o_ready), 32'd1);
        @(posedge i_clk);
        #1;

        circle(ramp, 1'b0, 8'hF0, 8'h0F, 24'h002D00);
        wait_idle();
        circle(flat, 1'b0, 8'hFF, 8'hFF, 24'h001000);
        wait_idle();
        circle(trunc, 1'b0, 8'h80, 8'h01, 24'h000001);
        wait_idle();

        // Backpressure with junk samples offered while the output is held.
        i_ready = 1'b0;
        circle(ramp, 1'b0, 8'hF0, 8'h0F, 24'h002D00);
        begin
            int t = 0;
            while (!o_valid && t < 100) begin
                @(negedge i_clk);
                t++;
            end
            if (t >= 100) check("valid_timeout", 32'(t), 32'd0);
        end
        i_valid  = 1'b1;
        i_sample = 24'hFFFFFF;
        repeat (5) begin
            @(negedge i_clk);
            check("bp_valid_held", 32'(o_valid), 32'd1);
        end
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        wait_idle();
        circle(flat, 1'b0, 8'hFF, 8'hFF, 24'h001000);
        wait_idle();

        circle(ramp, 1'b1, 8'hF0, 8'h0F, 24'h002D00);
        wait_idle();

        // Reset after a partial circle must discard it.
        send(24'h002222);
        send(24'h003333);
        send(24'h004444);
        i_rst_n = 1'b0;
        @(negedge i_clk);
        check("ready_in_rst", 32'(o_ready), 32'd0);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        circle(five, 1'b0, 8'hFF, 8'hFF, 24'h000500);
        wait_idle();

        repeat (20) @(negedge i_clk);
        check("outputs", 32'(outputs), 32'd7);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
